// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the shared word RAM and memory-mapped I/O registers.
// Build option MEM_ARB_FIXED_PRIO_EN: m0 always wins a tie instead of round-robin with burst limiting.
module mem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rd_data
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    logic             last_owner_q, last_owner_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_tag_q, rd_tag_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic             gnt0_s, gnt1_s, accept_s, winner_s, win_we_s;
    logic [WIDTH-1:0] win_addr_s, win_wdata_s;

    // Grant decision; a burst only continues once the owner has actually been granted (count != 0),
    // so after reset the tie falls to the master other than last_owner, i.e. m0.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt0_s = 1'b1;
            gnt1_s = 1'b0;
`else
            if ((burst_cnt_q != 4'd0) && (burst_cnt_q < MAX_CNT)) begin
                gnt0_s = ~last_owner_q;
                gnt1_s = last_owner_q;
            end else begin
                gnt0_s = last_owner_q;
                gnt1_s = ~last_owner_q;
            end
`endif
        end else begin
            gnt0_s = m0_req;
            gnt1_s = m1_req;
        end
    end

    // Winner mux feeding memory and the next-state logic
    always_comb begin
        accept_s    = gnt0_s | gnt1_s;
        winner_s    = gnt1_s;
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        if (gnt1_s) begin
            win_we_s    = m1_we;
            win_addr_s  = m1_addr;
            win_wdata_s = m1_wdata;
        end else begin
            win_we_s    = m0_we;
            win_addr_s  = m0_addr;
            win_wdata_s = m0_wdata;
        end
    end

    // Next state for burst tracking, held memory drive and the read-return tag
    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        rd_pend_d    = 1'b0;
        rd_tag_d     = rd_tag_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if (accept_s) begin
            addr_d    = win_addr_s;
            wdata_d   = win_wdata_s;
            rd_pend_d = ~win_we_s;
            rd_tag_d  = winner_s;
            if (winner_s == last_owner_q) begin
                if (burst_cnt_q < MAX_CNT) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end else begin
                last_owner_d = winner_s;
                burst_cnt_d  = 4'd1;
            end
        end else begin
            rd_pend_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_tag_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_tag_q     <= rd_tag_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Memory drive: live winner when granted, otherwise the held copy so the read select stays put
    always_comb begin
        m0_gnt = gnt0_s;
        m1_gnt = gnt1_s;
        if (accept_s) begin
            mem_address = win_addr_s;
            mem_wr_data = win_wdata_s;
            mem_write   = win_we_s;
        end else begin
            mem_address = addr_q;
            mem_wr_data = wdata_q;
            mem_write   = 1'b0;
        end
    end

    // Read return steered to the tagged master; the other rdata is forced to zero
    always_comb begin
        m0_rvalid = rd_pend_q & ~rd_tag_q;
        m1_rvalid = rd_pend_q & rd_tag_q;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (m0_rvalid) begin
            m0_rdata = mem_rd_data;
        end else if (m1_rvalid) begin
            m1_rdata = mem_rd_data;
        end else begin
            m0_rdata = '0;
            m1_rdata = '0;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter and sequencer for the shared memory subsystem: word RAM plus memory-mapped inport/outport registers.
- Master 0 is the CPU datapath; master 1 is the debug/boot loader.
- Chooses one master per cycle, drives the memory address, write data and write enable, and routes 1-cycle-latency read data back with a valid strobe.
- Burst limiting keeps one master from starving the other.

Parameters:
- WIDTH, 32, address and data width.
- MAX_BURST, 4, maximum consecutive accepted transfers for one master while the other master is requesting; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- m0_req  input  1  master 0 transfer request
- m0_we  input  1  master 0 write (1) / read (0)
- m0_addr  input  WIDTH  master 0 byte address
- m0_wdata  input  WIDTH  master 0 write data
- m0_gnt  output  1  master 0 request accepted this cycle
- m0_rvalid  output  1  master 0 read data valid
- m0_rdata  output  WIDTH  master 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- mem_address  output  WIDTH  address to memory
- mem_wr_data  output  WIDTH  write data to memory
- mem_write  output  1  memory write enable
- mem_rd_data  input  WIDTH  memory read data, valid one cycle after address

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values:
  - gnt, rvalid and mem_write all 0.
  - mem_address 0; burst_cnt 0; last_owner = 1, so m0 wins the first tie.
  - Pending read tag is cleared.
- Grant logic:
  - Combinational from the current req inputs and registered state.
  - At most one gnt is high per cycle.
  - A transfer is accepted when req && gnt in the same cycle.
  - Masters hold req, we, addr and wdata stable until gnt.
- Arbitration:
  - Only one master requesting: it is granted, subject to the burst rule below.
  - Both masters requesting: grant goes to owner if owner == last_owner and burst_cnt < MAX_BURST; otherwise grant goes to the master != last_owner (round-robin).
  - Neither requesting: no grant; burst_cnt is held.
- Burst counter:
  - An accepted transfer by last_owner increments burst_cnt, saturating at MAX_BURST.
  - An accepted transfer by the other master sets last_owner to that master and burst_cnt to 1.
  - A lone requester is granted every cycle even when burst_cnt == MAX_BURST; the count stays saturated.
- Memory drive:
  - On a granted cycle, mem_address, mem_wr_data and mem_write = winner's addr, wdata and we.
  - On a non-granted cycle, mem_write = 0 and mem_address holds the last granted address (registered copy), so the memory's registered read-select does not glitch. mem_wr_data holds its last value.
- Read return:
  - An accepted read sets rd_pend = 1 and rd_tag = winner, registered.
  - Next cycle: mX_rvalid = 1 for the tagged master, and mX_rdata = mem_rd_data (combinational pass-through).
  - Non-tagged rdata outputs are 0.
  - Writes produce no rvalid.
- Throughput:
  - Back-to-back reads are fully pipelined: one accepted per cycle, rvalid every cycle.
  - A read followed by a write in the next cycle is allowed; the rvalid for the read still fires in the write cycle.
- Reset mid-operation: a pending rvalid is dropped and does not appear after reset deasserts; arbitration restarts with m0 preferred.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; m0 always wins when both request. MAX_BURST and burst_cnt are ignored, and m1 is granted only when m0_req == 0.
- Undefined: round-robin with burst limiting, as specified above.

Test Plan:
- Reset, then m0 read addr 0x10 alone → m0_gnt = 1 in the same cycle, mem_address = 0x10, mem_write = 0; next cycle m0_rvalid = 1 and m0_rdata = mem_rd_data; m1_rvalid stays 0.
- Both masters request from the first cycle after reset → m0 granted first. With MAX_BURST = 4 and m0 requesting continuously: m0 gets 4 grants, then m1 gets 4, then m0.
- m1 writes 0x0000FFFC data 0xA5 with m0 idle → mem_write = 1 for exactly one cycle, mem_wr_data = 0xA5, no rvalid on either master.
- m0 read 0x20 followed immediately by m0 write 0x24 → two consecutive gnt; m0_rvalid is high only in the second cycle; mem_address 0x20 then 0x24, then held at 0x24 when idle.
- Assert rst while an m1 read is pending (cycle after its gnt) → m1_rvalid stays 0 through and after reset; all outputs are 0; the next simultaneous request goes to m0.
- With MEM_ARB_FIXED_PRIO_EN, both masters request for 10 cycles → m0_gnt is high all 10 cycles and m1_gnt stays 0; m1 is granted in the cycle m0_req drops.
